// File: rtl/ucsbece154a_controller_mc.sv
// Multicycle RV32I-subset control FSM with memory wait states and a gated SLEEP state.
// Define UCSBECE154A_SLEEP_TIMER_EN to build the SLEEP timeout counter.
module ucsbece154a_controller_mc #(
   parameter int WAKE_N  = 4,
   parameter int TIMER_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [6:0]         op_i,
   input  logic [2:0]         funct3_i,
   input  logic               funct7_i,
   input  logic               zero_i,
   input  logic               memready_i,
   input  logic [WAKE_N-1:0]  wake_i,
   input  logic [WAKE_N-1:0]  wakemask_i,
   input  logic [TIMER_W-1:0] sleepcycles_i,
   output logic               PCWrite_o,
   output logic               MemWrite_o,
   output logic               IRWrite_o,
   output logic               RegWrite_o,
   output logic               AdrSrc_o,
   output logic [1:0]         ALUSrcA_o,
   output logic [1:0]         ALUSrcB_o,
   output logic [1:0]         ResultSrc_o,
   output logic [2:0]         ALUControl_o,
   output logic [2:0]         ImmSrc_o,
   output logic               sleeping_o,
   output logic               illegal_o,
   output logic [WAKE_N:0]    wakecause_o
);

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_SLEEP = 7'b0001011;
   localparam logic [6:0] OP_WAKE  = 7'b0101011;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECR, S_EXECI, S_LUI, S_ALUWB, S_BEQ, S_JAL, S_SLEEP
   } state_t;

   state_t            state, state_n;
   logic [WAKE_N-1:0] wake_act;
   logic              wake_hit;
   logic              timeout_hit;
   logic              op_known;
   logic              branch;
   logic              pc_update;
   logic [1:0]        alu_op;

   assign wake_act = wake_i & wakemask_i;
   assign wake_hit = |wake_act;

`ifdef UCSBECE154A_SLEEP_TIMER_EN
   logic [TIMER_W-1:0] timer;
   // A zero load never reaches 1, so timeout is implicitly disabled.
   assign timeout_hit = (state == S_SLEEP) && (timer == TIMER_W'(1));
`else
   logic unused_sleepcycles;
   assign unused_sleepcycles = ^sleepcycles_i;
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      case (op_i)
         OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL, OP_LUI, OP_SLEEP, OP_WAKE:
            op_known = 1'b1;
         default: op_known = 1'b0;
      endcase
   end

   always_comb begin
      state_n = S_FETCH;
      case (state)
         S_FETCH:    state_n = memready_i ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op_i)
               OP_LW, OP_SW: state_n = S_MEMADR;
               OP_R:         state_n = S_EXECR;
               OP_I:         state_n = S_EXECI;
               OP_BEQ:       state_n = S_BEQ;
               OP_JAL:       state_n = S_JAL;
               OP_LUI:       state_n = S_LUI;
               OP_SLEEP:     state_n = S_SLEEP;
               default:      state_n = S_FETCH;
            endcase
         end
         S_MEMADR:   state_n = (op_i == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_n = memready_i ? S_MEMWB : S_MEMREAD;
         S_MEMWB:    state_n = S_FETCH;
         S_MEMWRITE: state_n = memready_i ? S_FETCH : S_MEMWRITE;
         S_EXECR:    state_n = S_ALUWB;
         S_EXECI:    state_n = S_ALUWB;
         S_LUI:      state_n = S_ALUWB;
         S_ALUWB:    state_n = S_FETCH;
         S_BEQ:      state_n = S_FETCH;
         S_JAL:      state_n = S_ALUWB;
         S_SLEEP:    state_n = (wake_hit || timeout_hit) ? S_FETCH : S_SLEEP;
         default:    state_n = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_FETCH;
         wakecause_o <= '0;
`ifdef UCSBECE154A_SLEEP_TIMER_EN
         timer       <= '0;
`endif
      end else begin
         state <= state_n;
         if (state == S_SLEEP && state_n == S_FETCH)
            wakecause_o <= {timeout_hit, wake_act};
`ifdef UCSBECE154A_SLEEP_TIMER_EN
         if (state == S_DECODE && state_n == S_SLEEP)
            timer <= sleepcycles_i;
         else if (state == S_SLEEP && timer != '0)
            timer <= timer - TIMER_W'(1);
`endif
      end
   end

   // Moore decode; everything is forced low while reset is held.
   always_comb begin
      PCWrite_o    = 1'b0;
      MemWrite_o   = 1'b0;
      IRWrite_o    = 1'b0;
      RegWrite_o   = 1'b0;
      AdrSrc_o     = 1'b0;
      ALUSrcA_o    = 2'b00;
      ALUSrcB_o    = 2'b00;
      ResultSrc_o  = 2'b00;
      ALUControl_o = 3'b000;
      ImmSrc_o     = 3'b000;
      sleeping_o   = 1'b0;
      illegal_o    = 1'b0;
      branch       = 1'b0;
      pc_update    = 1'b0;
      alu_op       = 2'b00;
      if (reset) begin
         case (op_i)
            OP_SW:   ImmSrc_o = 3'b001;
            OP_BEQ:  ImmSrc_o = 3'b010;
            OP_JAL:  ImmSrc_o = 3'b011;
            OP_LUI:  ImmSrc_o = 3'b100;
            default: ImmSrc_o = 3'b000;
         endcase
         case (state)
            S_FETCH: begin
               ALUSrcB_o   = 2'b10;
               ResultSrc_o = 2'b10;
               IRWrite_o   = memready_i;
               pc_update   = memready_i;
            end
            S_DECODE: begin
               ALUSrcA_o = 2'b01;
               ALUSrcB_o = 2'b01;
               illegal_o = ~op_known;
            end
            S_MEMADR: begin
               ALUSrcA_o = 2'b10;
               ALUSrcB_o = 2'b01;
            end
            S_MEMREAD: AdrSrc_o = 1'b1;
            S_MEMWB: begin
               ResultSrc_o = 2'b01;
               RegWrite_o  = 1'b1;
            end
            S_MEMWRITE: begin
               AdrSrc_o   = 1'b1;
               MemWrite_o = 1'b1;
            end
            S_EXECR: begin
               ALUSrcA_o = 2'b10;
               alu_op    = 2'b10;
            end
            S_EXECI: begin
               ALUSrcA_o = 2'b10;
               ALUSrcB_o = 2'b01;
               alu_op    = 2'b10;
            end
            S_LUI: begin
               ALUSrcA_o = 2'b11;
               ALUSrcB_o = 2'b01;
            end
            S_ALUWB: RegWrite_o = 1'b1;
            S_BEQ: begin
               ALUSrcA_o = 2'b10;
               alu_op    = 2'b01;
               branch    = 1'b1;
            end
            S_JAL: begin
               ALUSrcA_o = 2'b01;
               ALUSrcB_o = 2'b10;
               pc_update = 1'b1;
            end
            S_SLEEP: sleeping_o = 1'b1;
            default: ;
         endcase
      end
      PCWrite_o = (branch & zero_i) | pc_update;
      case (alu_op)
         2'b00: ALUControl_o = 3'b000;
         2'b01: ALUControl_o = 3'b001;
         default: begin
            case (funct3_i)
               3'b000:  ALUControl_o = (funct7_i & op_i[5]) ? 3'b001 : 3'b000;
               3'b010:  ALUControl_o = 3'b101;
               3'b110:  ALUControl_o = 3'b011;
               3'b111:  ALUControl_o = 3'b010;
               default: ALUControl_o = 3'b000;
            endcase
         end
      endcase
   end

endmodule

// File: tb/tb_ucsbece154a_controller_mc.sv
// Directed bench for ucsbece154a_controller_mc: per-cycle output vectors for each instruction class.
module tb_ucsbece154a_controller_mc;

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  op_i;
   logic [2:0]  funct3_i;
   logic        funct7_i, zero_i, memready_i;
   logic [3:0]  wake_i, wakemask_i;
   logic [15:0] sleepcycles_i;
   logic        PCWrite_o, MemWrite_o, IRWrite_o, RegWrite_o, AdrSrc_o;
   logic [1:0]  ALUSrcA_o, ALUSrcB_o, ResultSrc_o;
   logic [2:0]  ALUControl_o, ImmSrc_o;
   logic        sleeping_o, illegal_o;
   logic [4:0]  wakecause_o;

   int tests = 0;
   int fails = 0;

   ucsbece154a_controller_mc #(.WAKE_N(4), .TIMER_W(16)) dut (
      .clk(clk), .reset(reset), .op_i(op_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
      .zero_i(zero_i), .memready_i(memready_i), .wake_i(wake_i), .wakemask_i(wakemask_i),
      .sleepcycles_i(sleepcycles_i), .PCWrite_o(PCWrite_o), .MemWrite_o(MemWrite_o),
      .IRWrite_o(IRWrite_o), .RegWrite_o(RegWrite_o), .AdrSrc_o(AdrSrc_o),
      .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .ResultSrc_o(ResultSrc_o),
      .ALUControl_o(ALUControl_o), .ImmSrc_o(ImmSrc_o), .sleeping_o(sleeping_o),
      .illegal_o(illegal_o), .wakecause_o(wakecause_o)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_LUI = 7'b0110111, OP_SLEEP = 7'b0001011, OP_WAKE = 7'b0101011;

   // {PCW,MemW,IRW,RegW,AdrSrc}, SrcA, SrcB, ResultSrc, ALUControl, ImmSrc, {sleeping,illegal}
   localparam logic [18:0] E_FW  = {5'b00000, 2'b00, 2'b10, 2'b10, 3'b000, 3'b000, 2'b00};
   localparam logic [18:0] E_FR  = {5'b10100, 2'b00, 2'b10, 2'b10, 3'b000, 3'b000, 2'b00};
   localparam logic [18:0] E_DEC = {5'b00000, 2'b01, 2'b01, 2'b00, 3'b000, 3'b000, 2'b00};
   localparam logic [18:0] E_MA  = {5'b00000, 2'b10, 2'b01, 2'b00, 3'b000, 3'b000, 2'b00};
   localparam logic [18:0] E_MR  = {5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 2'b00};
   localparam logic [18:0] E_MWB = {5'b00010, 2'b00, 2'b00, 2'b01, 3'b000, 3'b000, 2'b00};
   localparam logic [18:0] E_MW  = {5'b01001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 2'b00};
   localparam logic [18:0] E_XR  = {5'b00000, 2'b10, 2'b00, 2'b00, 3'b000, 3'b000, 2'b00};
   localparam logic [18:0] E_XI  = {5'b00000, 2'b10, 2'b01, 2'b00, 3'b000, 3'b000, 2'b00};
   localparam logic [18:0] E_LUI = {5'b00000, 2'b11, 2'b01, 2'b00, 3'b000, 3'b000, 2'b00};
   localparam logic [18:0] E_AWB = {5'b00010, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 2'b00};
   localparam logic [18:0] E_BEQ = {5'b00000, 2'b10, 2'b00, 2'b00, 3'b001, 3'b000, 2'b00};
   localparam logic [18:0] E_JAL = {5'b10000, 2'b01, 2'b10, 2'b00, 3'b000, 3'b000, 2'b00};
   localparam logic [18:0] E_SLP = {5'b00000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 2'b10};
   localparam logic [18:0] PCW   = 19'h40000;

   function automatic logic [18:0] obs();
      return {PCWrite_o, MemWrite_o, IRWrite_o, RegWrite_o, AdrSrc_o, ALUSrcA_o, ALUSrcB_o,
              ResultSrc_o, ALUControl_o, ImmSrc_o, sleeping_o, illegal_o};
   endfunction

   task automatic test_reset();
      #3;
      tests++;
      if (obs() !== 19'd0) begin $display("FAIL reset_outs got %b want %b", obs(), 19'd0); fails++; end
      tests++;
      if (wakecause_o !== 5'd0) begin $display("FAIL reset_cause got %b want 00000", wakecause_o); fails++; end
      @(negedge clk); #1;
      tests++;
      if (obs() !== 19'd0) begin $display("FAIL reset_held got %b want %b", obs(), 19'd0); fails++; end
      @(negedge clk); reset = 1'b1; #1;
      tests++;
      if (obs() !== E_FW) begin $display("FAIL reset_fetch got %b want %b", obs(), E_FW); fails++; end
   endtask

   task automatic test_add();
      logic [18:0] ev [5];
      logic        rd [5];
      ev = '{E_FR, E_DEC, E_XR, E_AWB, E_FW};
      rd = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      op_i = OP_R; funct3_i = 3'b000; funct7_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); memready_i = rd[i]; #1;
         tests++;
         if (obs() !== ev[i]) begin $display("FAIL add c%0d got %b want %b", i, obs(), ev[i]); fails++; end
      end
   endtask

   task automatic test_alu_decode();
      logic [6:0]  ops [6];
      logic [2:0]  f3s [6];
      logic        f7s [6];
      logic [2:0]  alus [6];
      logic [18:0] ev [5];
      ops  = '{OP_R, OP_R, OP_R, OP_R, OP_I, OP_I};
      f3s  = '{3'b000, 3'b111, 3'b010, 3'b100, 3'b110, 3'b000};
      f7s  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      alus = '{3'b001, 3'b010, 3'b101, 3'b000, 3'b011, 3'b000};
      for (int t = 0; t < 6; t++) begin
         op_i = ops[t]; funct3_i = f3s[t]; funct7_i = f7s[t];
         ev = '{E_FR, E_DEC, ((ops[t] == OP_I) ? E_XI : E_XR) | (19'(alus[t]) << 5), E_AWB, E_FW};
         for (int i = 0; i < 5; i++) begin
            @(negedge clk); memready_i = (i != 4); #1;
            tests++;
            if (obs() !== ev[i]) begin
               $display("FAIL alu t%0d c%0d got %b want %b", t, i, obs(), ev[i]); fails++;
            end
         end
      end
      funct3_i = 3'b000; funct7_i = 1'b0;
   endtask

   task automatic test_lw_wait();
      logic [18:0] ev [9];
      logic        rd [9];
      ev = '{E_FW, E_FR, E_DEC, E_MA, E_MR, E_MR, E_MR, E_MWB, E_FW};
      rd = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      op_i = OP_LW;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk); memready_i = rd[i]; #1;
         tests++;
         if (obs() !== ev[i]) begin $display("FAIL lw c%0d got %b want %b", i, obs(), ev[i]); fails++; end
      end
   endtask

   task automatic test_sw();
      logic [18:0] ev [6];
      logic        rd [6];
      logic [18:0] im;
      im = 19'(3'b001) << 2;
      ev = '{E_FR | im, E_DEC | im, E_MA | im, E_MW | im, E_MW | im, E_FW | im};
      rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      op_i = OP_SW;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); memready_i = rd[i]; #1;
         tests++;
         if (obs() !== ev[i]) begin $display("FAIL sw c%0d got %b want %b", i, obs(), ev[i]); fails++; end
      end
   endtask

   task automatic test_beq();
      logic [18:0] ev [4];
      logic [18:0] im;
      im = 19'(3'b010) << 2;
      op_i = OP_BEQ;
      for (int z = 1; z >= 0; z--) begin
         zero_i = z[0];
         ev = '{E_FR | im, E_DEC | im, E_BEQ | im | (z[0] ? PCW : 19'd0), E_FW | im};
         for (int i = 0; i < 4; i++) begin
            @(negedge clk); memready_i = (i != 3); #1;
            tests++;
            if (obs() !== ev[i]) begin
               $display("FAIL beq z%0d c%0d got %b want %b", z, i, obs(), ev[i]); fails++;
            end
         end
      end
      zero_i = 1'b0;
   endtask

   task automatic test_jal_lui();
      logic [18:0] ev [5];
      logic [18:0] im;
      for (int t = 0; t < 2; t++) begin
         op_i = (t == 0) ? OP_JAL : OP_LUI;
         im   = 19'((t == 0) ? 3'b011 : 3'b100) << 2;
         ev   = '{E_FR | im, E_DEC | im, ((t == 0) ? E_JAL : E_LUI) | im, E_AWB | im, E_FW | im};
         for (int i = 0; i < 5; i++) begin
            @(negedge clk); memready_i = (i != 4); #1;
            tests++;
            if (obs() !== ev[i]) begin
               $display("FAIL jal_lui t%0d c%0d got %b want %b", t, i, obs(), ev[i]); fails++;
            end
         end
      end
   endtask

   task automatic test_illegal_wakeup();
      logic [18:0] ev [3];
      for (int t = 0; t < 2; t++) begin
         op_i = (t == 0) ? 7'b1111111 : OP_WAKE;
         ev   = '{E_FR, E_DEC | ((t == 0) ? 19'd1 : 19'd0), E_FW};
         for (int i = 0; i < 3; i++) begin
            @(negedge clk); memready_i = (i != 2); #1;
            tests++;
            if (obs() !== ev[i]) begin
               $display("FAIL illegal t%0d c%0d got %b want %b", t, i, obs(), ev[i]); fails++;
            end
         end
      end
   endtask

   task automatic test_sleep_timeout();
`ifdef UCSBECE154A_SLEEP_TIMER_EN
      logic [18:0] ev [8];
      logic [18:0] ev2 [4];
      op_i = OP_SLEEP; sleepcycles_i = 16'd5; wakemask_i = 4'b0000; wake_i = 4'b0000;
      ev = '{E_FR, E_DEC, E_SLP, E_SLP, E_SLP, E_SLP, E_SLP, E_FW};
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); memready_i = (i < 2); #1;
         tests++;
         if (obs() !== ev[i]) begin $display("FAIL timeout c%0d got %b want %b", i, obs(), ev[i]); fails++; end
      end
      tests++;
      if (wakecause_o !== 5'b10000) begin $display("FAIL timeout_cause got %b want 10000", wakecause_o); fails++; end
      // timeout of 1 coinciding with an entry-edge wake sets both cause fields
      sleepcycles_i = 16'd1; wakemask_i = 4'b0010; wake_i = 4'b0010;
      ev2 = '{E_FR, E_DEC, E_SLP, E_FW};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); memready_i = (i < 2); #1;
         tests++;
         if (obs() !== ev2[i]) begin $display("FAIL both c%0d got %b want %b", i, obs(), ev2[i]); fails++; end
      end
      tests++;
      if (wakecause_o !== 5'b10010) begin $display("FAIL both_cause got %b want 10010", wakecause_o); fails++; end
`else
      logic [18:0] ev [11];
      logic [3:0]  wk [11];
      op_i = OP_SLEEP; sleepcycles_i = 16'd5;
      ev = '{E_FR, E_DEC, E_SLP, E_SLP, E_SLP, E_SLP, E_SLP, E_SLP, E_SLP, E_SLP, E_FW};
      wk = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0};
      for (int i = 0; i < 11; i++) begin
         @(negedge clk); memready_i = (i < 2); wake_i = wk[i]; wakemask_i = wk[i]; #1;
         tests++;
         if (obs() !== ev[i]) begin $display("FAIL notimer c%0d got %b want %b", i, obs(), ev[i]); fails++; end
      end
      tests++;
      if (wakecause_o !== 5'b00001) begin $display("FAIL notimer_cause got %b want 00001", wakecause_o); fails++; end
`endif
      wake_i = 4'b0000; wakemask_i = 4'b0000; sleepcycles_i = 16'd0;
   endtask

   task automatic test_sleep_wake();
      logic [18:0] ev [7];
      logic [3:0]  wk [7];
      logic [18:0] ev2 [4];
      op_i = OP_SLEEP; sleepcycles_i = 16'd0; wakemask_i = 4'b0100;
      ev = '{E_FR, E_DEC, E_SLP, E_SLP, E_SLP, E_SLP, E_FW};
      wk = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0110, 4'd0};
      for (int i = 0; i < 7; i++) begin
         @(negedge clk); memready_i = (i < 2); wake_i = wk[i]; #1;
         tests++;
         if (obs() !== ev[i]) begin $display("FAIL wake c%0d got %b want %b", i, obs(), ev[i]); fails++; end
      end
      tests++;
      if (wakecause_o !== 5'b00100) begin $display("FAIL wake_cause got %b want 00100", wakecause_o); fails++; end
      // wake already asserted on the entry edge: single SLEEP cycle
      wakemask_i = 4'b0001; wake_i = 4'b0001;
      ev2 = '{E_FR, E_DEC, E_SLP, E_FW};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); memready_i = (i < 2); #1;
         tests++;
         if (obs() !== ev2[i]) begin $display("FAIL dwell c%0d got %b want %b", i, obs(), ev2[i]); fails++; end
      end
      tests++;
      if (wakecause_o !== 5'b00001) begin $display("FAIL dwell_cause got %b want 00001", wakecause_o); fails++; end
      // fully masked wake with no timeout never leaves SLEEP
      wakemask_i = 4'b0000; wake_i = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); memready_i = (i < 2); #1;
         tests++;
         if (obs() !== ((i == 0) ? E_FR : (i == 1) ? E_DEC : E_SLP)) begin
            $display("FAIL masked c%0d got %b", i, obs()); fails++;
         end
      end
      #2 reset = 1'b0; #1;
      tests++;
      if (obs() !== 19'd0) begin $display("FAIL masked_reset got %b want %b", obs(), 19'd0); fails++; end
      tests++;
      if (wakecause_o !== 5'd0) begin $display("FAIL masked_cause got %b want 00000", wakecause_o); fails++; end
      @(negedge clk); reset = 1'b1; wake_i = 4'b0000; memready_i = 1'b0; #1;
      tests++;
      if (obs() !== E_FW) begin $display("FAIL masked_fetch got %b want %b", obs(), E_FW); fails++; end
   endtask

   task automatic test_reset_mid();
      logic [18:0] ev [4];
      logic [18:0] im;
      im = 19'(3'b001) << 2;
      ev = '{E_FR | im, E_DEC | im, E_MA | im, E_MW | im};
      op_i = OP_SW;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); memready_i = (i < 3); #1;
         tests++;
         if (obs() !== ev[i]) begin $display("FAIL rstmid c%0d got %b want %b", i, obs(), ev[i]); fails++; end
      end
      #2 reset = 1'b0; #1;
      tests++;
      if (MemWrite_o !== 1'b0 || obs() !== 19'd0) begin
         $display("FAIL rstmid_async got %b want %b", obs(), 19'd0); fails++;
      end
      @(negedge clk); reset = 1'b1; #1;
      tests++;
      if (obs() !== (E_FW | im)) begin $display("FAIL rstmid_fetch got %b want %b", obs(), E_FW | im); fails++; end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      reset = 1'b0; op_i = 7'd0; funct3_i = 3'd0; funct7_i = 1'b0; zero_i = 1'b0;
      memready_i = 1'b0; wake_i = 4'd0; wakemask_i = 4'd0; sleepcycles_i = 16'd0;
      test_reset();
      test_add();
      test_alu_decode();
      test_lw_wait();
      test_sw();
      test_beq();
      test_jal_lui();
      test_illegal_wakeup();
      test_sleep_timeout();
      test_sleep_wake();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ucsbece154a_controller_mc.md
# ucsbece154a_controller_mc

Parametrised next-generation multicycle control FSM for the RV32I-subset core, with a memory ready/wait handshake and a gated sleep state. It decodes `op_i`/`funct3_i`/`funct7_i` and drives the datapath selects and enables. It stalls memory states until `memready_i`, and leaves SLEEP on any of `WAKE_N` maskable wake lines or an optional cycle timeout.

## Interface
- `WAKE_N`, 4: number of external wake sources (1..16)
- `TIMER_W`, 16: sleep-timeout counter width
- `clk` in 1: sole clock, rising edge
- `reset` in 1: asynchronous, active-low; clears state and all flops
- `op_i` in 7: opcode; `funct3_i` in 3; `funct7_i` in 1 (instr bit 30); `zero_i` in 1: ALU zero flag
- `memready_i` in 1: memory access completes this cycle
- `wake_i` in WAKE_N: level wake requests; `wakemask_i` in WAKE_N: 1 = enabled
- `sleepcycles_i` in TIMER_W: timeout loaded on SLEEP entry; 0 = no timeout
- `PCWrite_o`, `MemWrite_o`, `IRWrite_o`, `RegWrite_o`, `AdrSrc_o` out 1
- `ALUSrcA_o`, `ALUSrcB_o`, `ResultSrc_o` out 2; `ALUControl_o`, `ImmSrc_o` out 3
- `sleeping_o` out 1: in SLEEP, for clock gating; `illegal_o` out 1: one-cycle pulse on an unknown opcode
- `wakecause_o` out WAKE_N+1: {timeout, masked wake lines} latched at SLEEP exit

## Operation
- Opcodes: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011, jal 1101111, lui 0110111, sleep 0001011, wakeup 0101011.
- ImmSrc (combinational on `op_i`): lw/I 000, sw 001, beq 010, jal 011, lui 100, others 000.
- ALUOp: 00 gives add. 01 gives sub. 10 decodes `funct3_i`:
  - 000: sub if `funct7_i & op_i[5]`, else add
  - 010 slt, 110 or, 111 and, others 000
  - ALUControl encodings: add 000, sub 001, and 010, or 011, slt 101.
- Outputs are Moore-decoded from the current state. Every output not listed for a state is 0. `PCWrite_o = (Branch & zero_i) | PCUpdate`.
- FETCH: AdrSrc 0, SrcA 00, SrcB 10, ResultSrc 10. IRWrite and PCUpdate are 1 only when `memready_i`. Stay in FETCH until `memready_i`, then go to DECODE.
- DECODE: SrcA 01, SrcB 01. Next state by opcode:
  - lw/sw → MEMADR; R → EXECR; I → EXECI; beq → BEQ; jal → JAL; lui → LUI
  - sleep → SLEEP; wakeup → FETCH
  - any other opcode → FETCH with `illegal_o` = 1 for that cycle
- MEMADR: SrcA 10, SrcB 01. Next is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: AdrSrc 1. Wait for `memready_i`, then go to MEMWB.
- MEMWB: ResultSrc 01, RegWrite 1; then FETCH.
- MEMWRITE: AdrSrc 1, MemWrite 1, held until `memready_i`; then FETCH.
- EXECR: SrcA 10, SrcB 00, ALUOp 10 → ALUWB.
- EXECI: SrcA 10, SrcB 01, ALUOp 10 → ALUWB.
- LUI: SrcA 11 (zero), SrcB 01 → ALUWB.
- ALUWB: RegWrite 1 → FETCH.
- BEQ: SrcA 10, SrcB 00, ALUOp 01, Branch 1 → FETCH.
- JAL: SrcA 01, SrcB 10, PCUpdate 1 → ALUWB.
- SLEEP entry (DECODE→SLEEP edge): timer ← `sleepcycles_i`.
- SLEEP: `sleeping_o` = 1, all enables 0, timer decrements when nonzero. Exit to FETCH when either holds:
  - `wake_i & wakemask_i` != 0
  - timer == 1 and timeout enabled
- SLEEP exit: `wakecause_o` ← {timeout_hit, `wake_i & wakemask_i`}. Both fields are set if both conditions occur in the same cycle.
- PC was already advanced in FETCH, so execution resumes at sleep PC+4.
- `wakecause_o` holds until the next SLEEP exit.
- An all-masked wake with `sleepcycles_i` = 0 stays in SLEEP until reset.

## Timing
- Reset value of every output is 0 (state FETCH, timer 0, `wakecause_o` 0). FETCH outputs appear immediately after reset deassertion.
- Minimum latencies at zero wait states:
  - lw: 5 cycles
  - sw: 4 cycles
  - R/I/lui/jal: 4 cycles
  - beq: 3 cycles
  - sleep: 2 cycles, plus dwell time
- Each cycle with `memready_i` low adds exactly one cycle in FETCH, MEMREAD or MEMWRITE.
- Wake is sampled each SLEEP cycle, and FETCH starts the next cycle. Wake asserted on the entry edge is seen in the first SLEEP cycle, giving a 1-cycle dwell.
- Timeout N ≥ 1 gives exactly N cycles in SLEEP.
- `reset` asserted mid-instruction returns immediately to FETCH, with no write enables.

## Configuration
- `UCSBECE154A_SLEEP_TIMER_EN` defined: the timeout counter is built as above.
- Undefined: no counter is built. `sleepcycles_i` is ignored, SLEEP exits only on masked wake, and `wakecause_o[WAKE_N]` is tied to 0.

## Test plan
- add x3,x1,x2 (op 0110011, f3 000, f7 0), `memready_i` = 1 → states F,D,EXECR,ALUWB, ALUControl 000 in EXECR, RegWrite only in cycle 4.
- lw with `memready_i` low for 2 cycles in MEMREAD → 7-cycle instruction; RegWrite pulses once, in MEMWB.
- beq with `zero_i` = 1 vs 0 → `PCWrite_o` = 1 vs 0 in BEQ; ALUControl 001.
- sleep, `sleepcycles_i` = 5, mask 0000 → exactly 5 SLEEP cycles; `wakecause_o` = 5'b10000.
- sleep, `sleepcycles_i` = 0, mask 0100, `wake_i` = 0110 after 3 cycles → exit next cycle; `wakecause_o` = 5'b00100; wake with mask 0 never exits.
- opcode 1111111 → DECODE→FETCH, `illegal_o` pulses 1 cycle; `reset` low during MEMWRITE clears `MemWrite_o` asynchronously.
